// File: rtl/affine_interp_pkg.sv
// Shared constants for the affine interpolation filter blocks: tap coefficients,
// phase-code encodings and the product-width rule used by every MCM pipe.
package affine_interp_pkg;

  localparam int COEF_T2_60 = 60;
  localparam int COEF_T2_45 = 45;
  localparam int COEF_T2_26 = 26;
  localparam int COEF_INT   = 64;

  localparam logic [1:0] SEL_60  = 2'd0;
  localparam logic [1:0] SEL_45  = 2'd1;
  localparam logic [1:0] SEL_26  = 2'd2;
  localparam logic [1:0] SEL_INT = 2'd3;

  // 64 is the largest coefficient magnitude, so six extra bits hold 64*min without wrap.
  localparam int MCM_GUARD_BITS = 6;

  function automatic int mcm_out_w(input int in_w);
    return in_w + MCM_GUARD_BITS;
  endfunction

endpackage

// File: rtl/affine_tap2_mcm_core.sv
// Combinational shift-add multiple-constant multiplier for tap 2.
// The stage-A half builds the shared partials w15 and w13 from X; the stage-B half
// turns registered partials into X*60, X*45, X*26 and the integer-position X*64.
// All arithmetic is OUT_W-bit two's complement and wraps if OUT_W is made narrow.
module affine_tap2_mcm_core #(
  parameter int OUT_W = 14
) (
  input  logic signed [OUT_W-1:0] a_x,
  output logic signed [OUT_W-1:0] a_w15,
  output logic signed [OUT_W-1:0] a_w13,
  input  logic signed [OUT_W-1:0] b_x,
  input  logic signed [OUT_W-1:0] b_w15,
  input  logic signed [OUT_W-1:0] b_w13,
  output logic signed [OUT_W-1:0] b_w60,
  output logic signed [OUT_W-1:0] b_w45,
  output logic signed [OUT_W-1:0] b_w26,
  output logic signed [OUT_W-1:0] b_w64
);

  // Stage-A partials: 15X = 16X - X, and 13X reuses 15X by removing 2X.
  always_comb begin
    a_w15 = (a_x <<< 4) - a_x;
    a_w13 = a_w15 - (a_x <<< 1);
  end

  // Stage-B products: 60X = 4*15X, 45X = 60X - 15X, 26X = 2*13X, 64X is a pure shift.
  always_comb begin
    b_w60 = b_w15 <<< 2;
    b_w45 = b_w60 - b_w15;
    b_w26 = b_w13 <<< 1;
    b_w64 = b_x <<< 6;
  end

endmodule

// File: rtl/affine_tap2_mcm_pipe.sv
// Two-stage valid/ready pipeline around the tap-2 MCM core. Stage A captures the
// sample, its phase code and the shared partials; stage B holds the three fixed
// products plus the one product picked by the phase code. Full backpressure: a
// stalled output holds stable and the input stalls once both stages are occupied.
module affine_tap2_mcm_pipe
  import affine_interp_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = mcm_out_w(IN_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [IN_W-1:0]  s_x,
  input  logic [1:0]              s_sel,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_y60,
  output logic signed [OUT_W-1:0] m_y45,
  output logic signed [OUT_W-1:0] m_y26,
  output logic signed [OUT_W-1:0] m_ysel
);

  logic                    v_a;
  logic                    v_b;
  logic                    en_a;
  logic                    en_b;
  logic signed [OUT_W-1:0] x_ext;
  logic signed [OUT_W-1:0] x_a;
  logic [1:0]              sel_a;
  logic signed [OUT_W-1:0] w15_a;
  logic signed [OUT_W-1:0] w13_a;
  logic signed [OUT_W-1:0] w15_nx;
  logic signed [OUT_W-1:0] w13_nx;
  logic signed [OUT_W-1:0] w60_nx;
  logic signed [OUT_W-1:0] w45_nx;
  logic signed [OUT_W-1:0] w26_nx;
  logic signed [OUT_W-1:0] w64_nx;
  logic signed [OUT_W-1:0] ysel_nx;

  // A stage may load when it is empty or when the stage after it is moving on,
  // so s_ready depends combinationally on m_ready.
  assign en_b    = !v_b || m_ready;
  assign en_a    = !v_a || en_b;
  assign s_ready = en_a;
  assign m_valid = v_b;

  // Sign-extend (or, for a deliberately narrow OUT_W, truncate) the sample.
  assign x_ext = OUT_W'(s_x);

  affine_tap2_mcm_core #(
    .OUT_W(OUT_W)
  ) u_core (
    .a_x  (x_ext),
    .a_w15(w15_nx),
    .a_w13(w13_nx),
    .b_x  (x_a),
    .b_w15(w15_a),
    .b_w13(w13_a),
    .b_w60(w60_nx),
    .b_w45(w45_nx),
    .b_w26(w26_nx),
    .b_w64(w64_nx)
  );

  // Phase-code mux picks the product that the filter tap needs for this sample.
  always_comb begin
    ysel_nx = w64_nx;
    case (sel_a)
      SEL_60:  ysel_nx = w60_nx;
      SEL_45:  ysel_nx = w45_nx;
      SEL_26:  ysel_nx = w26_nx;
      SEL_INT: ysel_nx = w64_nx;
      default: ysel_nx = w64_nx;
    endcase
  end

  // Stage A register bank: data only changes when a real sample is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_a   <= 1'b0;
      x_a   <= '0;
      sel_a <= '0;
      w15_a <= '0;
      w13_a <= '0;
    end else if (en_a) begin
      v_a <= s_valid;
      if (s_valid) begin
        x_a   <= x_ext;
        sel_a <= s_sel;
        w15_a <= w15_nx;
        w13_a <= w13_nx;
      end
    end
  end

  // Stage B register bank: holds while stalled, takes over stage A's sample otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_b    <= 1'b0;
      m_y60  <= '0;
      m_y45  <= '0;
      m_y26  <= '0;
      m_ysel <= '0;
    end else if (en_b) begin
      v_b <= v_a;
      if (v_a) begin
        m_y60  <= w60_nx;
        m_y45  <= w45_nx;
        m_y26  <= w26_nx;
        m_ysel <= ysel_nx;
      end
    end
  end

endmodule

// File: tb/tb_affine_tap2_mcm_pipe.sv
// Directed and randomised checks of the tap-2 MCM pipe: reset state, exact latency,
// extreme samples, streaming, backpressure, mid-flight reset and ordering.
module tb_affine_tap2_mcm_pipe;
  import affine_interp_pkg::*;

  localparam int IN_W  = 8;
  localparam int OUT_W = 14;

  typedef struct packed {
    logic signed [OUT_W-1:0] y60;
    logic signed [OUT_W-1:0] y45;
    logic signed [OUT_W-1:0] y26;
    logic signed [OUT_W-1:0] ysel;
  } prod_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic signed [IN_W-1:0]  s_x = '0;
  logic [1:0]              s_sel = '0;
  logic                    m_valid;
  logic                    m_ready = 1'b0;
  logic signed [OUT_W-1:0] m_y60;
  logic signed [OUT_W-1:0] m_y45;
  logic signed [OUT_W-1:0] m_y26;
  logic signed [OUT_W-1:0] m_ysel;

  int vectors = 0;
  int miscompares = 0;

  prod_t obs;
  assign obs = '{y60: m_y60, y45: m_y45, y26: m_y26, ysel: m_ysel};

  affine_tap2_mcm_pipe #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_x    (s_x),
    .s_sel  (s_sel),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_y60  (m_y60),
    .m_y45  (m_y45),
    .m_y26  (m_y26),
    .m_ysel (m_ysel)
  );

  always #5 clk = ~clk;

  // Reference products by plain multiplication.
  function automatic prod_t model(input int x, input logic [1:0] sel);
    prod_t e;
    int c;
    case (sel)
      SEL_60:  c = COEF_T2_60;
      SEL_45:  c = COEF_T2_45;
      SEL_26:  c = COEF_T2_26;
      default: c = COEF_INT;
    endcase
    e.y60  = OUT_W'(x * COEF_T2_60);
    e.y45  = OUT_W'(x * COEF_T2_45);
    e.y26  = OUT_W'(x * COEF_T2_26);
    e.ysel = OUT_W'(x * c);
    return e;
  endfunction

  // Empty the pipe between scenarios without checking anything.
  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({m_valid, s_ready, obs} !== {1'b0, 1'b1, prod_t'('0)})
      $display("[TB] FAIL reset_state: got valid=%b ready=%b y=%h, want valid=0 ready=1 y=0",
               m_valid, s_ready, obs);
    if ({m_valid, s_ready, obs} !== {1'b0, 1'b1, prod_t'('0)}) miscompares++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    prod_t want;
    want = '{y60: 14'sd180, y45: 14'sd135, y26: 14'sd78, ysel: 14'sd180};
    @(negedge clk);
    s_valid = 1'b1; s_x = 8'sd3; s_sel = SEL_60; m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    vectors++;
    if (m_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_latency1: got m_valid=%b, want 0", m_valid);
    end
    @(negedge clk); #1;
    vectors++;
    if ({m_valid, obs} !== {1'b1, want}) begin
      miscompares++;
      $display("[TB] FAIL single_x3: got v=%b %0d/%0d/%0d/%0d, want v=1 180/135/78/180",
               m_valid, obs.y60, obs.y45, obs.y26, obs.ysel);
    end
    @(negedge clk); #1;
    vectors++;
    if (m_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_nodup: got m_valid=%b, want 0", m_valid);
    end
    drain();
  endtask

  task automatic test_extremes();
    logic signed [IN_W-1:0] xs [2];
    logic [1:0]             ss [2];
    prod_t                  ws [2];
    xs[0] = -8'sd128; ss[0] = SEL_INT;
    ws[0] = '{y60: -14'sd7680, y45: -14'sd5760, y26: -14'sd3328, ysel: -14'sd8192};
    xs[1] = 8'sd127;  ss[1] = SEL_26;
    ws[1] = '{y60: 14'sd7620, y45: 14'sd5715, y26: 14'sd3302, ysel: 14'sd3302};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_x = xs[i]; s_sel = ss[i]; m_ready = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      @(negedge clk); #1;
      vectors++;
      if ({m_valid, obs} !== {1'b1, ws[i]}) begin
        miscompares++;
        $display("[TB] FAIL extreme_%0d: got v=%b %0d/%0d/%0d/%0d, want v=1 %0d/%0d/%0d/%0d",
                 i, m_valid, obs.y60, obs.y45, obs.y26, obs.ysel,
                 ws[i].y60, ws[i].y45, ws[i].y26, ws[i].ysel);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    prod_t want;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      m_ready = 1'b1;
      if (k < 16) begin
        s_valid = 1'b1; s_x = IN_W'(k + 1); s_sel = 2'(k % 4);
      end else begin
        s_valid = 1'b0;
      end
      #1;
      vectors++;
      if (s_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_ready_%0d: got s_ready=%b, want 1", k, s_ready);
      end
      if (k >= 2) begin
        want = model(k - 1, 2'((k - 2) % 4));
        vectors++;
        if ({m_valid, obs} !== {1'b1, want}) begin
          miscompares++;
          $display("[TB] FAIL b2b_out_%0d: got v=%b %0d/%0d/%0d/%0d, want v=1 %0d/%0d/%0d/%0d",
                   k - 2, m_valid, obs.y60, obs.y45, obs.y26, obs.ysel,
                   want.y60, want.y45, want.y26, want.ysel);
        end
      end
    end
    @(negedge clk); #1;
    vectors++;
    if (m_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_tail: got m_valid=%b, want 0", m_valid);
    end
    drain();
  endtask

  task automatic test_backpressure();
    prod_t q[$];
    prod_t held;
    prod_t want;
    logic  stalled = 1'b0;
    logic  saw_full = 1'b0;
    int    sent = 0;
    int    got = 0;
    int    cyc = 0;
    while (got < 8 && cyc < 40) begin
      @(negedge clk);
      s_valid = (sent < 8);
      s_x = IN_W'(sent + 1);
      s_sel = 2'(sent % 4);
      m_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      if (stalled) begin
        vectors++;
        if ({m_valid, obs} !== {1'b1, held}) begin
          miscompares++;
          $display("[TB] FAIL bp_stable_c%0d: got v=%b y=%h, want v=1 y=%h", cyc, m_valid, obs, held);
        end
      end
      if (m_valid && s_valid && !s_ready) saw_full = 1'b1;
      if (m_valid && m_ready) begin
        want = q.pop_front();
        vectors++;
        if (obs !== want) begin
          miscompares++;
          $display("[TB] FAIL bp_out_%0d: got %0d/%0d/%0d/%0d, want %0d/%0d/%0d/%0d", got,
                   obs.y60, obs.y45, obs.y26, obs.ysel, want.y60, want.y45, want.y26, want.ysel);
        end
        got++;
      end
      stalled = m_valid && !m_ready;
      held = obs;
      if (s_valid && s_ready) begin
        q.push_back(model(sent + 1, 2'(sent % 4)));
        sent++;
      end
      cyc++;
    end
    vectors++;
    if (got != 8 || saw_full !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_summary: got %0d outputs full=%b, want 8 outputs full=1", got, saw_full);
    end
    drain();
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    m_ready = 1'b0; s_valid = 1'b1; s_x = 8'sd5; s_sel = SEL_60;
    @(negedge clk);
    s_x = 8'sd6; s_sel = SEL_45;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    vectors++;
    if ({m_valid, s_ready} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL flush_full: got m_valid=%b s_ready=%b, want 1 0", m_valid, s_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({m_valid, s_ready, obs} !== {1'b0, 1'b1, prod_t'('0)}) begin
      miscompares++;
      $display("[TB] FAIL flush_state: got valid=%b ready=%b y=%h, want 0 1 0", m_valid, s_ready, obs);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      vectors++;
      if (m_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL flush_ghost_%0d: got m_valid=%b, want 0", k, m_valid);
      end
    end
  endtask

  task automatic test_random();
    prod_t q[$];
    prod_t held;
    prod_t want;
    logic  stalled = 1'b0;
    int    n = 10000;
    int    sent = 0;
    int    got = 0;
    int    cyc = 0;
    while (got < n && cyc < 40000) begin
      @(negedge clk);
      s_valid = (sent < n) && ($urandom_range(3) != 0);
      s_x = IN_W'($urandom);
      s_sel = 2'($urandom_range(3));
      m_ready = ($urandom_range(3) != 0);
      #1;
      if (stalled) begin
        vectors++;
        if ({m_valid, obs} !== {1'b1, held}) begin
          miscompares++;
          $display("[TB] FAIL rand_stable_c%0d: got v=%b y=%h, want v=1 y=%h", cyc, m_valid, obs, held);
        end
      end
      if (m_valid && m_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL rand_extra_c%0d: got unexpected output y=%h, want none", cyc, obs);
        end else begin
          want = q.pop_front();
          if (obs !== want) begin
            miscompares++;
            $display("[TB] FAIL rand_out_%0d: got y=%h, want y=%h", got, obs, want);
          end
        end
        got++;
      end
      stalled = m_valid && !m_ready;
      held = obs;
      if (s_valid && s_ready) begin
        q.push_back(model(s_x, s_sel));
        sent++;
      end
      cyc++;
    end
    vectors++;
    if (got != n || q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL rand_count: got %0d outputs (%0d left), want %0d (0 left)", got, q.size(), n);
    end
    drain();
  endtask

  // Scenario sequence and the single summary line.
  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
